// File: rtl/pwm_shadow_bank_pkg.sv
// -----------------------------------------------------------------------------
// PKG_pwm : shared types for the PWM compare/duty path.
//   _pwm_onoff        : PWM enable state (PWM_OFF / PWM_ON).
//   _upd_mode         : shadow transfer event select.
//   `PWMCOUNT_WIDTH   : carrier counter / compare width (default 16).
// No ports (package only).
// -----------------------------------------------------------------------------
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

package PKG_pwm;

    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_ON  = 1'b1
    } _pwm_onoff;

    typedef enum logic [1:0] {
        UPD_IMMEDIATE = 2'd0,
        UPD_ZERO      = 2'd1,
        UPD_TOP       = 2'd2,
        UPD_BOTH      = 2'd3
    } _upd_mode;

    localparam int PWMCOUNT_W = `PWMCOUNT_WIDTH;

endpackage

// File: rtl/pwm_shadow_bank_chan.sv
// -----------------------------------------------------------------------------
// pwm_shadow_chan : one channel of the shadow bank (staging, active, dirty).
//   clk, reset_n : clock, synchronous active-low reset
//   wr_en        : staging write strobe
//   wr_data      : staging write data
//   period       : clamp limit (only with PWM_SHADOW_CLAMP_EN defined)
//   xfer         : shared transfer strobe, copies staging into active
//   act          : active value (registered)
//   dirty        : written but not yet transferred (registered)
// Build option: PWM_SHADOW_CLAMP_EN clamps staged data to period.
// -----------------------------------------------------------------------------
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

module pwm_shadow_chan
    import PKG_pwm::*;
#(
    parameter int WIDTH = `PWMCOUNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
`ifdef PWM_SHADOW_CLAMP_EN
    input  logic [WIDTH-1:0] period,
`endif
    input  logic             xfer,
    output logic [WIDTH-1:0] act,
    output logic             dirty
);

    logic [WIDTH-1:0] stage_r;
    logic [WIDTH-1:0] wr_val_s;

    // Value that a staging write stores (optionally limited to the period)
    always_comb begin
`ifdef PWM_SHADOW_CLAMP_EN
        if (wr_data > period) begin
            wr_val_s = period;
        end else begin
            wr_val_s = wr_data;
        end
`else
        wr_val_s = wr_data;
`endif
    end

    // Staging/active/dirty state; a transfer always copies the pre-write stage
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_r <= {WIDTH{1'b0}};
            act     <= {WIDTH{1'b0}};
            dirty   <= 1'b0;
        end else begin
            if (xfer) begin
                act <= stage_r;
            end
            if (wr_en) begin
                stage_r <= wr_val_s;
                dirty   <= 1'b1;
            end else if (xfer) begin
                dirty   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pwm_shadow_bank.sv
// -----------------------------------------------------------------------------
// pwm_shadow_bank : multi-channel shadow/active register bank.
//   clk, reset_n : clock, synchronous active-low reset
//   pwm_onoff    : PWM_OFF makes the bank transparent every cycle
//   evt_zero     : carrier-at-zero strobe
//   evt_top      : carrier-at-top strobe
//   upd_mode     : transfer event select
//   upd_div      : transfer on every (upd_div+1)-th qualifying event
//   lock         : holds all transfers while high (PWM_ON only)
//   period       : clamp limit (used only with PWM_SHADOW_CLAMP_EN)
//   wr_en        : per-channel staging write strobes
//   wr_data      : packed staging data, channel k at [k*WIDTH +: WIDTH]
//   act_out      : packed active values
//   dirty        : per-channel written-not-transferred flags
//   upd_pulse    : high the cycle act_out reflects a transfer
// Build option: PWM_SHADOW_CLAMP_EN.
// -----------------------------------------------------------------------------
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

module pwm_shadow_bank
    import PKG_pwm::*;
#(
    parameter int NCH   = 8,
    parameter int WIDTH = `PWMCOUNT_WIDTH,
    parameter int DIV_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  _pwm_onoff            pwm_onoff,
    input  logic                 evt_zero,
    input  logic                 evt_top,
    input  _upd_mode             upd_mode,
    input  logic [DIV_W-1:0]     upd_div,
    input  logic                 lock,
    input  logic [WIDTH-1:0]     period,
    input  logic [NCH-1:0]       wr_en,
    input  logic [NCH*WIDTH-1:0] wr_data,
    output logic [NCH*WIDTH-1:0] act_out,
    output logic [NCH-1:0]       dirty,
    output logic                 upd_pulse
);

    logic             qev_s;
    logic             xfer_s;
    logic [DIV_W-1:0] div_cnt_r;
    logic [DIV_W-1:0] div_cnt_nxt_s;

`ifndef PWM_SHADOW_CLAMP_EN
    logic             unused_period_s;
    assign unused_period_s = ^period;
`endif

    // Qualifying event select; both strobes together count once
    always_comb begin
        case (upd_mode)
            UPD_IMMEDIATE: qev_s = 1'b1;
            UPD_ZERO:      qev_s = evt_zero;
            UPD_TOP:       qev_s = evt_top;
            UPD_BOTH:      qev_s = evt_zero | evt_top;
            default:       qev_s = 1'b0;
        endcase
    end

    // Transfer decision and divider next state; >= lets a lowered upd_div fire at once
    always_comb begin
        if (pwm_onoff == PWM_OFF) begin
            xfer_s        = 1'b1;
            div_cnt_nxt_s = {DIV_W{1'b0}};
        end else if (lock) begin
            xfer_s        = 1'b0;
            div_cnt_nxt_s = div_cnt_r;
        end else if (qev_s) begin
            if (div_cnt_r >= upd_div) begin
                xfer_s        = 1'b1;
                div_cnt_nxt_s = {DIV_W{1'b0}};
            end else begin
                xfer_s        = 1'b0;
                div_cnt_nxt_s = div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end else begin
            xfer_s        = 1'b0;
            div_cnt_nxt_s = div_cnt_r;
        end
    end

    // Event divider counter and registered transfer strobe
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_r <= {DIV_W{1'b0}};
            upd_pulse <= 1'b0;
        end else begin
            div_cnt_r <= div_cnt_nxt_s;
            upd_pulse <= xfer_s;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        pwm_shadow_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_en   (wr_en[k]),
            .wr_data (wr_data[k*WIDTH +: WIDTH]),
`ifdef PWM_SHADOW_CLAMP_EN
            .period  (period),
`endif
            .xfer    (xfer_s),
            .act     (act_out[k*WIDTH +: WIDTH]),
            .dirty   (dirty[k])
        );
    end

endmodule

// File: tb/tb_pwm_shadow_bank.sv
// -----------------------------------------------------------------------------
// tb_pwm_shadow_bank : directed scenarios plus randomized traffic, each cycle
// compared against a behavioural model of the shadow bank.
// -----------------------------------------------------------------------------
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

module tb_pwm_shadow_bank;
    import PKG_pwm::*;

    localparam int NCH   = 8;
    localparam int WIDTH = 16;
    localparam int DIV_W = 4;

    logic                 clk = 1'b0;
    logic                 reset_n;
    _pwm_onoff            pwm_onoff;
    logic                 evt_zero;
    logic                 evt_top;
    _upd_mode             upd_mode;
    logic [DIV_W-1:0]     upd_div;
    logic                 lock;
    logic [WIDTH-1:0]     period;
    logic [NCH-1:0]       wr_en;
    logic [NCH*WIDTH-1:0] wr_data;
    logic [NCH*WIDTH-1:0] act_out;
    logic [NCH-1:0]       dirty;
    logic                 upd_pulse;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [WIDTH-1:0] m_stage [NCH];
    logic [WIDTH-1:0] m_act   [NCH];
    logic [NCH-1:0]   m_dirty;
    logic             m_pulse;
    int               m_events;   // qualifying events seen since last transfer

    always #5 clk = ~clk;

    pwm_shadow_bank #(
        .NCH   (NCH),
        .WIDTH (WIDTH),
        .DIV_W (DIV_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pwm_onoff (pwm_onoff),
        .evt_zero  (evt_zero),
        .evt_top   (evt_top),
        .upd_mode  (upd_mode),
        .upd_div   (upd_div),
        .lock      (lock),
        .period    (period),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .act_out   (act_out),
        .dirty     (dirty),
        .upd_pulse (upd_pulse)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] chan_of(input logic [NCH*WIDTH-1:0] v, input int k);
        return v[k*WIDTH +: WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] staged_value(input logic [WIDTH-1:0] d);
`ifdef PWM_SHADOW_CLAMP_EN
        return (d > period) ? period : d;
`else
        return d;
`endif
    endfunction

    // Apply one clock edge to the model using the currently driven inputs
    task automatic model_edge();
        bit ev;
        bit do_xfer;
        if (!reset_n) begin
            for (int k = 0; k < NCH; k++) begin
                m_stage[k] = '0;
                m_act[k]   = '0;
            end
            m_dirty  = '0;
            m_pulse  = 1'b0;
            m_events = 0;
        end else begin
            ev = (upd_mode == UPD_IMMEDIATE) ||
                 (upd_mode == UPD_ZERO && evt_zero) ||
                 (upd_mode == UPD_TOP  && evt_top) ||
                 (upd_mode == UPD_BOTH && (evt_zero || evt_top));
            do_xfer = 1'b0;
            if (pwm_onoff == PWM_OFF) begin
                do_xfer  = 1'b1;
                m_events = 0;
            end else if (!lock && ev) begin
                // the (upd_div+1)-th event fires; a lowered divider fires on the next one
                if (m_events >= int'(upd_div)) begin
                    do_xfer  = 1'b1;
                    m_events = 0;
                end else begin
                    m_events = m_events + 1;
                end
            end
            for (int k = 0; k < NCH; k++) begin
                if (do_xfer) m_act[k] = m_stage[k];
                if (wr_en[k]) begin
                    m_stage[k] = staged_value(wr_data[k*WIDTH +: WIDTH]);
                    m_dirty[k] = 1'b1;
                end else if (do_xfer) begin
                    m_dirty[k] = 1'b0;
                end
            end
            m_pulse = do_xfer;
        end
    endtask

    // Advance one cycle and compare every output with the model
    task automatic step(input string tag);
        logic [NCH*WIDTH-1:0] exp_act;
        @(negedge clk);
        model_edge();
        @(posedge clk);
        #1;
        for (int k = 0; k < NCH; k++) exp_act[k*WIDTH +: WIDTH] = m_act[k];
        check({tag, ".act"}, act_out, exp_act);
        check({tag, ".dirty"}, dirty, m_dirty);
        check({tag, ".pulse"}, upd_pulse, m_pulse);
    endtask

    task automatic write_ch(input int k, input logic [WIDTH-1:0] v);
        wr_en = '0;
        wr_en[k] = 1'b1;
        wr_data = '0;
        wr_data[k*WIDTH +: WIDTH] = v;
    endtask

    task automatic idle_inputs();
        wr_en    = '0;
        evt_zero = 1'b0;
        evt_top  = 1'b0;
    endtask

    initial begin
        logic [NCH*WIDTH-1:0] exp_all;

        reset_n   = 1'b0;
        pwm_onoff = PWM_OFF;
        upd_mode  = UPD_IMMEDIATE;
        upd_div   = '0;
        lock      = 1'b0;
        period    = 16'h03E8;
        evt_zero  = 1'b0;
        evt_top   = 1'b0;
        wr_en     = '1;
        wr_data   = {NCH{16'hBEEF}};

        // reset with all write strobes active
        step("reset");
        step("reset2");
        check("reset.act_zero", act_out, 128'd0);
        check("reset.dirty_zero", dirty, 8'h00);
        check("reset.pulse_zero", upd_pulse, 1'b0);
        reset_n = 1'b1;
        idle_inputs();
        step("off_idle");

        // PWM_OFF passthrough
        write_ch(3, 16'h1234);
        step("off_wr");
        check("off.dirty_set", dirty[3], 1'b1);
        idle_inputs();
        step("off_xfer");
        check("off.ch3", chan_of(act_out, 3), 16'h1234);
        check("off.dirty_clr", dirty[3], 1'b0);
        check("off.pulse", upd_pulse, 1'b1);

        // zero mode with divider 2: transfer on the 3rd zero event
        pwm_onoff = PWM_ON;
        upd_mode  = UPD_ZERO;
        upd_div   = 4'd2;
        write_ch(0, 16'h0100);
        step("div_wr");
        idle_inputs();
        step("div_idle");
        for (int p = 1; p <= 3; p++) begin
            evt_zero = 1'b1;
            step("div_evt");
            evt_zero = 1'b0;
            check("div.ch0", chan_of(act_out, 0), (p == 3) ? 16'h0100 : 16'h0000);
            check("div.pulse", upd_pulse, (p == 3) ? 1'b1 : 1'b0);
            step("div_gap");
            check("div.pulse_single", upd_pulse, 1'b0);
        end

        // lock atomicity under UPD_TOP
        upd_mode = UPD_TOP;
        upd_div  = 4'd0;
        lock     = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            write_ch(k, 16'h1000 + 16'(k));
            step("lock_wr");
        end
        idle_inputs();
        evt_top = 1'b1;
        step("lock_evt");
        evt_top = 1'b0;
        check("lock.held_pulse", upd_pulse, 1'b0);
        check("lock.dirty_all", dirty, 8'hFF);
        check("lock.ch5_old", chan_of(act_out, 5), 16'h0000);
        lock = 1'b0;
        step("unlock_idle");
        evt_top = 1'b1;
        step("unlock_evt");
        evt_top = 1'b0;
        for (int k = 0; k < NCH; k++) exp_all[k*WIDTH +: WIDTH] = 16'h1000 + 16'(k);
        check("unlock.all", act_out, exp_all);
        check("unlock.dirty", dirty, 8'h00);
        check("unlock.pulse", upd_pulse, 1'b1);

        // write/transfer collision
        upd_mode = UPD_ZERO;
        write_ch(1, 16'h5555);
        step("col_pre");
        idle_inputs();
        evt_zero = 1'b1;
        step("col_pre_xfer");
        check("col.pre", chan_of(act_out, 1), 16'h5555);
        write_ch(1, 16'hAAAA);
        step("col_hit");
        idle_inputs();
        check("col.old_value", chan_of(act_out, 1), 16'h5555);
        check("col.dirty", dirty[1], 1'b1);
        evt_zero = 1'b1;
        step("col_next");
        evt_zero = 1'b0;
        check("col.new_value", chan_of(act_out, 1), 16'hAAAA);
        check("col.dirty_clr", dirty[1], 1'b0);

`ifdef PWM_SHADOW_CLAMP_EN
        // clamp to period under PWM_OFF
        pwm_onoff = PWM_OFF;
        period    = 16'h03E8;
        write_ch(2, 16'hFFFF);
        step("clamp_wr");
        idle_inputs();
        step("clamp_xfer");
        check("clamp.ch2", chan_of(act_out, 2), 16'h03E8);
`endif

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset_n   = ($urandom_range(0, 299) != 0);
            pwm_onoff = ($urandom_range(0, 9) == 0) ? PWM_OFF : PWM_ON;
            if ($urandom_range(0, 15) == 0) upd_mode = _upd_mode'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) upd_div  = DIV_W'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0)  lock     = ~lock;
            evt_zero = ($urandom_range(0, 3) == 0);
            evt_top  = ($urandom_range(0, 3) == 0);
            period   = 16'($urandom);
            for (int k = 0; k < NCH; k++) begin
                wr_en[k] = ($urandom_range(0, 5) == 0);
                wr_data[k*WIDTH +: WIDTH] = 16'($urandom);
            end
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
